// File: rtl/known_ch_pkg.sv
// Shared types and constants for the known-cluster-head table.
package known_ch_pkg;

    localparam int WORD_WIDTH = 16;
    localparam logic [WORD_WIDTH-1:0] HOPS_INVALID = 16'hFFFF;
    localparam logic [WORD_WIDTH-1:0] Q_ONE = 16'h4000;

    typedef struct packed {
        logic                  valid;
        logic [WORD_WIDTH-1:0] id;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] q;
    } ch_entry_t;

endpackage

// File: rtl/known_ch_v2_better.sv
// Pairwise CH preference: fewer hops, then higher Q, and on a full tie the
// newer (higher-index) entry wins.
module kch_better
    import known_ch_pkg::*;
(
    input  ch_entry_t older,
    input  ch_entry_t newer,
    output ch_entry_t winner
);

    logic newerWins;

    always_comb begin
        newerWins = 1'b0;
        if (newer.valid) begin
            if (!older.valid) begin
                newerWins = 1'b1;
            end else if (newer.hops < older.hops) begin
                newerWins = 1'b1;
            end else if ((newer.hops == older.hops) && (newer.q >= older.q)) begin
                newerWins = 1'b1;
            end
        end
        winner = newerWins ? newer : older;
    end

endmodule

// File: rtl/known_ch_v2.sv
// Known cluster-head table with registered best-CH selection.
// Optional macro KCH_SELF_FILTER_EN drops advertisements carrying OWN_ID.
module known_ch_v2 #(
    parameter int WORD_WIDTH = 16,
    parameter int MAX_CH = 8,
    parameter logic [WORD_WIDTH-1:0] OWN_ID = 16'd12
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_KCH,
    input  logic                  HB_reset,
    input  logic [WORD_WIDTH-1:0] fCH_ID,
    input  logic [WORD_WIDTH-1:0] fCH_Hops,
    input  logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic [WORD_WIDTH-1:0] chosenCH,
    output logic [WORD_WIDTH-1:0] hopsfromCH
);

    import known_ch_pkg::*;

    localparam int IDX_W = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;

    ch_entry_t slots [MAX_CH];
    ch_entry_t bestEntry;

    logic             selfAdvert;
    logic             accept;
    logic             matchHit;
    logic             freeHit;
    logic [IDX_W-1:0] matchIdx;
    logic [IDX_W-1:0] freeIdx;

`ifdef KCH_SELF_FILTER_EN
    assign selfAdvert = (fCH_ID == OWN_ID);
`else
    assign selfAdvert = 1'b0;
`endif

    assign accept = en_KCH && (fCH_Hops != HOPS_INVALID) && !selfAdvert;

    // Descending scan so the lowest free slot is the one left standing.
    always_comb begin
        matchHit = 1'b0;
        matchIdx = '0;
        freeHit  = 1'b0;
        freeIdx  = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (slots[i].valid && (slots[i].id == fCH_ID)) begin
                matchHit = 1'b1;
                matchIdx = IDX_W'(i);
            end
            if (!slots[i].valid) begin
                freeHit = 1'b1;
                freeIdx = IDX_W'(i);
            end
        end
    end

    // Linear reduction chain; later slots sit on the 'newer' side.
    for (genvar g = 0; g < MAX_CH; g++) begin : gSel
        ch_entry_t best;
        if (g == 0) begin : gFirst
            assign best = slots[0];
        end else begin : gStage
            kch_better uBetter (
                .older (gSel[g-1].best),
                .newer (slots[g]),
                .winner(best)
            );
        end
    end

    assign bestEntry = gSel[MAX_CH-1].best;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < MAX_CH; i++) begin
                slots[i].valid <= 1'b0;
            end
            chosenCH   <= '0;
            hopsfromCH <= HOPS_INVALID;
        end else begin
            if (HB_reset) begin
                for (int i = 0; i < MAX_CH; i++) begin
                    slots[i].valid <= 1'b0;
                end
            end else if (accept) begin
                if (matchHit) begin
                    slots[matchIdx].hops <= fCH_Hops;
                    slots[matchIdx].q    <= fCH_QValue;
                end else if (freeHit) begin
                    slots[freeIdx] <= '{valid: 1'b1, id: fCH_ID, hops: fCH_Hops, q: fCH_QValue};
                end
            end
            chosenCH   <= bestEntry.valid ? bestEntry.id : '0;
            hopsfromCH <= bestEntry.valid ? bestEntry.hops : HOPS_INVALID;
        end
    end

endmodule

// File: tb/tb_known_ch_v2.sv
// Self-checking bench for known_ch_v2: cycle scoreboard plus directed checks.
module tb_known_ch_v2;

    localparam int MAX_CH = 8;
    localparam logic [15:0] OWN_ID = 16'd12;

    logic        clk;
    logic        nrst;
    logic        en_KCH;
    logic        HB_reset;
    logic [15:0] fCH_ID;
    logic [15:0] fCH_Hops;
    logic [15:0] fCH_QValue;
    logic [15:0] chosenCH;
    logic [15:0] hopsfromCH;

    int compareCount = 0;
    int mismatchCount = 0;

    typedef struct {
        logic [15:0] id;
        logic [15:0] hops;
    } exp_t;

    exp_t sbQ [$];

    logic        mValid [MAX_CH];
    logic [15:0] mId    [MAX_CH];
    logic [15:0] mHops  [MAX_CH];
    logic [15:0] mQ     [MAX_CH];

    known_ch_v2 #(.WORD_WIDTH(16), .MAX_CH(MAX_CH), .OWN_ID(OWN_ID)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en_KCH    (en_KCH),
        .HB_reset  (HB_reset),
        .fCH_ID    (fCH_ID),
        .fCH_Hops  (fCH_Hops),
        .fCH_QValue(fCH_QValue),
        .chosenCH  (chosenCH),
        .hopsfromCH(hopsfromCH)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference selection: minimum hops, then maximum Q, then latest slot.
    task automatic modelSelect(output logic [15:0] id, output logic [15:0] hops);
        logic [15:0] minH;
        logic [15:0] maxQ;
        bit any;
        any = 0;
        minH = 16'hFFFF;
        maxQ = 16'h0000;
        id = 16'h0000;
        hops = 16'hFFFF;
        for (int i = 0; i < MAX_CH; i++)
            if (mValid[i]) begin
                any = 1;
                if (mHops[i] < minH) minH = mHops[i];
            end
        for (int i = 0; i < MAX_CH; i++)
            if (mValid[i] && mHops[i] == minH && mQ[i] > maxQ) maxQ = mQ[i];
        for (int i = 0; i < MAX_CH; i++)
            if (any && mValid[i] && mHops[i] == minH && mQ[i] == maxQ) begin
                id = mId[i];
                hops = mHops[i];
            end
    endtask

    task automatic modelStep();
        exp_t e;
        bit done;
        bit selfIgnore;
        if (!nrst) begin
            e.id = 16'h0000;
            e.hops = 16'hFFFF;
        end else begin
            modelSelect(e.id, e.hops);
        end
        sbQ.push_back(e);
        selfIgnore = 0;
`ifdef KCH_SELF_FILTER_EN
        selfIgnore = (fCH_ID == OWN_ID);
`endif
        if (!nrst || HB_reset) begin
            for (int i = 0; i < MAX_CH; i++) mValid[i] = 0;
        end else if (en_KCH && fCH_Hops != 16'hFFFF && !selfIgnore) begin
            done = 0;
            for (int i = 0; i < MAX_CH; i++)
                if (!done && mValid[i] && mId[i] == fCH_ID) begin
                    mHops[i] = fCH_Hops;
                    mQ[i] = fCH_QValue;
                    done = 1;
                end
            for (int i = 0; i < MAX_CH; i++)
                if (!done && !mValid[i]) begin
                    mValid[i] = 1;
                    mId[i] = fCH_ID;
                    mHops[i] = fCH_Hops;
                    mQ[i] = fCH_QValue;
                    done = 1;
                end
        end
    endtask

    initial for (int i = 0; i < MAX_CH; i++) mValid[i] = 0;

    always @(posedge clk) modelStep();

    // Outputs settle after the rising edge; compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("sbChosenCH", chosenCH, e.id);
            checkOutput("sbHops", hopsfromCH, e.hops);
        end
    end

    // Drives one cycle of inputs starting at a falling edge, leaves them idle.
    task automatic applyStimulus(input logic en, input logic hb, input logic [15:0] id,
                                 input logic [15:0] hops, input logic [15:0] q);
        en_KCH = en;
        HB_reset = hb;
        fCH_ID = id;
        fCH_Hops = hops;
        fCH_QValue = q;
        @(posedge clk);
        @(negedge clk);
        en_KCH = 0;
        HB_reset = 0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic expectChosen(input string tag, input logic [15:0] id, input logic [15:0] hops);
        idleCycles(1);
        checkOutput({tag, "Id"}, chosenCH, id);
        checkOutput({tag, "Hops"}, hopsfromCH, hops);
    endtask

    initial begin
        nrst = 0;
        en_KCH = 0;
        HB_reset = 0;
        fCH_ID = 0;
        fCH_Hops = 0;
        fCH_QValue = 0;
        @(negedge clk);
        idleCycles(2);
        nrst = 1;
        expectChosen("resetIdle", 16'h0000, 16'hFFFF);

        applyStimulus(1, 0, 16'd23, 16'd2, 16'h3000);
        expectChosen("first23", 16'd23, 16'd2);
        applyStimulus(1, 0, 16'd45, 16'd2, 16'h2000);
        expectChosen("higherQ", 16'd23, 16'd2);
        applyStimulus(1, 0, 16'd6, 16'd1, 16'h4000);
        expectChosen("fewerHops", 16'd6, 16'd1);
        applyStimulus(1, 0, 16'd65, 16'd1, 16'h4000);
        expectChosen("newestTie", 16'd65, 16'd1);
        applyStimulus(1, 0, 16'd65, 16'd3, 16'h4000);
        expectChosen("inPlace", 16'd6, 16'd1);

        applyStimulus(0, 1, 16'h0, 16'h0, 16'h0);
        expectChosen("hbClear", 16'h0000, 16'hFFFF);
        applyStimulus(1, 1, 16'd77, 16'd1, 16'h4000);
        expectChosen("hbWins", 16'h0000, 16'hFFFF);
        applyStimulus(1, 0, 16'd90, 16'd2, 16'h1000);
        expectChosen("no77", 16'd90, 16'd2);

        // Back-to-back fill past capacity, then a would-be winner that must drop.
        applyStimulus(0, 1, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i <= MAX_CH; i++) applyStimulus(1, 0, 16'(100 + i), 16'd5, 16'h1000);
        applyStimulus(1, 0, 16'd200, 16'd1, 16'h4000);
        expectChosen("fullDrop", 16'(100 + MAX_CH - 1), 16'd5);
        applyStimulus(1, 0, 16'd101, 16'hFFFF, 16'h4000);
        expectChosen("invalidHops", 16'(100 + MAX_CH - 1), 16'd5);
        applyStimulus(1, 0, 16'd100, 16'd2, 16'h0800);
        expectChosen("fullUpdate", 16'd100, 16'd2);

        applyStimulus(0, 1, 16'h0, 16'h0, 16'h0);
        applyStimulus(1, 0, 16'd23, 16'd2, 16'h3000);
        applyStimulus(1, 0, OWN_ID, 16'd1, 16'h4000);
`ifdef KCH_SELF_FILTER_EN
        expectChosen("selfFilter", 16'd23, 16'd2);
`else
        expectChosen("selfStored", OWN_ID, 16'd1);
`endif

        nrst = 0;
        applyStimulus(1, 0, 16'd9, 16'd0, 16'h4000);
        nrst = 1;
        expectChosen("nrstPriority", 16'h0000, 16'hFFFF);

        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0) applyStimulus(0, 1, 16'h0, 16'h0, 16'h0);
            else if (r == 1) applyStimulus(1, 0, 16'($urandom_range(1, 12)), 16'hFFFF, 16'h4000);
            else if (r == 2) idleCycles(1);
            else applyStimulus(1, 0, 16'($urandom_range(1, 12)), 16'($urandom_range(0, 6)),
                               {2'($urandom_range(0, 3)), 14'h0});
        end
        idleCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/known_ch_v2.md
KNOWN_CH_V2 -- requirements
Module: known_ch_v2

Interface
REQ-001 Parameter: WORD_WIDTH, 16, width of all data ports.
REQ-002 Parameter: MAX_CH, 8, number of known-cluster-head table slots.
REQ-003 Parameter: OWN_ID, 16'd12, this node's ID; used only with KCH_SELF_FILTER_EN.
REQ-004 Ports SHALL be:
- clk  in  1  sole clock; all state changes on the rising edge.
- nrst  in  1  reset; synchronous and active-low.
- en_KCH  in  1  one-cycle strobe; fCH_* hold a valid CH advertisement.
- HB_reset  in  1  heartbeat received; clears all CH knowledge.
- fCH_ID  in  16  advertised CH node ID.
- fCH_Hops  in  16  hops to that CH; 16'hFFFF means invalid.
- fCH_QValue  in  16  unsigned Q2.14 Q-value (16'h4000 = 1.00).
- chosenCH  out  16  ID of the selected CH.
- hopsfromCH  out  16  hops to the selected CH.

Function
REQ-005 Table SHALL hold MAX_CH slots {valid, ID, hops, Q}, filled in arrival order from slot 0.
REQ-006 On en_KCH=1 with fCH_ID already valid in the table, that slot's hops and Q SHALL be overwritten in place.
REQ-007 On en_KCH=1 with a new ID, the lowest free slot SHALL be written; if the table is full, the advertisement SHALL be dropped.
REQ-008 en_KCH with fCH_Hops=16'hFFFF SHALL be ignored.
REQ-009 Selection over valid slots SHALL be: fewer hops wins; on equal hops, higher Q wins (unsigned compare); on full tie, higher slot index wins, so the newest arrival wins.
REQ-010 chosenCH/hopsfromCH SHALL be registered and reflect a table write on the rising edge after the write edge (1-cycle latency).
REQ-011 en_KCH asserted on consecutive cycles SHALL each be accepted; there is no busy state.
REQ-012 With no valid slot, the outputs SHALL be chosenCH=16'h0000 and hopsfromCH=16'hFFFF.
REQ-013 HB_reset=1 SHALL invalidate all slots; the outputs SHALL return to the REQ-012 values on the next edge.
REQ-014 When HB_reset and en_KCH are asserted in the same cycle, HB_reset SHALL win and the write SHALL be discarded.

Reset
REQ-015 nrst=0 at a rising edge SHALL invalidate all slots and set chosenCH=16'h0000, hopsfromCH=16'hFFFF; nrst SHALL take priority over HB_reset and en_KCH.
REQ-016 Table data fields need not be cleared on reset; only the valid bits matter.

Configuration
REQ-017 With KCH_SELF_FILTER_EN defined, en_KCH with fCH_ID==OWN_ID SHALL be ignored.
REQ-018 Without KCH_SELF_FILTER_EN, the OWN_ID parameter SHALL be unused and such an advertisement SHALL be stored like any other.

Structure
REQ-019 Package known_ch_pkg SHALL hold WORD_WIDTH, HOPS_INVALID (16'hFFFF), Q_ONE (16'h4000) and typedef ch_entry_t {valid, id, hops, q}.
REQ-020 A sub-module kch_better SHALL combinationally compare two ch_entry_t per REQ-009; the selection reduction SHALL be built from it.

Verification
REQ-021 Reset, then idle -> chosenCH=0, hopsfromCH=16'hFFFF.
REQ-022 Write (23,2,16'h3000), then (45,2,16'h2000) -> chosen 23/2 after the first write, still 23/2 after the second (higher Q wins on equal hops).
REQ-023 Then write (6,1,16'h4000) -> 6/1; then (65,1,16'h4000) -> 65/1 (full tie, newest wins); then (65,3,16'h4000) -> 6/1 (in-place update forces reselection).
REQ-024 HB_reset pulse, including one coincident with en_KCH (77,1,16'h4000) -> 0/FFFF and 77 not stored.
REQ-025 Write MAX_CH+1 distinct IDs with hops 5, extra ID with hops 1 -> extra ID dropped, chosen is not it; a write with hops=FFFF -> no change.
REQ-026 With KCH_SELF_FILTER_EN defined, write (12,1,16'h4000) after 23/2 -> chosen stays 23; without the macro -> chosen becomes 12/1.
